// File: rtl/load_store_align_pkg.sv
// Shared types and helpers for the load/store alignment stage.
package load_store_align_pkg;

    localparam int MAX_DATA_W = 64;
    localparam int MAX_BYTES  = MAX_DATA_W / 8;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } size_e;

    typedef struct packed {
        logic [MAX_DATA_W-1:0] data;
        logic [MAX_BYTES-1:0]  be;
        logic                  err;
    } rsp_t;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/load_store_align_format.sv
// Combinational lane select, extension, replication and error detect.
module lsa_format
    import load_store_align_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int BYTES  = DATA_W / 8,
    parameter int OFF_W  = $clog2(BYTES)
) (
    input  logic              req_store,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [OFF_W-1:0]  req_off,
    input  logic [DATA_W-1:0] req_rdata,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [DATA_W-1:0] fmt_data,
    output logic [BYTES-1:0]  fmt_be,
    output logic              fmt_err
);

    logic [3:0]        n_bytes;
    logic              illegal;
    logic              misaligned;
    logic [OFF_W+2:0]  sh_amt;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] st_data;
    logic [BYTES-1:0]  st_be;
    logic              sign_bit;
    int                fw;

    assign n_bytes    = size_bytes(req_size);
    assign illegal    = n_bytes > 4'(BYTES);
    assign misaligned = |(req_off & OFF_W'(n_bytes - 4'd1));
    assign sh_amt     = {req_off, 3'b000};
    assign shifted    = req_rdata >> sh_amt;

    always_comb begin
        fw       = DATA_W;
        sign_bit = shifted[DATA_W-1];
        st_data  = req_wdata;
        unique case (size_e'(req_size))
            SZ_BYTE: begin
                fw       = 8;
                sign_bit = shifted[7];
                st_data  = {BYTES{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                fw       = 16;
                sign_bit = shifted[15];
                st_data  = {(BYTES/2){req_wdata[15:0]}};
            end
            SZ_WORD: begin
                fw       = 32;
                sign_bit = shifted[31];
                st_data  = {(BYTES/4){req_wdata[31:0]}};
            end
            SZ_DWORD: begin
                fw       = DATA_W;
                sign_bit = shifted[DATA_W-1];
                st_data  = req_wdata;
            end
        endcase
    end

    // Bits above the field take the sign bit only for signed loads.
    always_comb begin
        ld_data = shifted;
        for (int i = 0; i < DATA_W; i++) begin
            if (i >= fw) ld_data[i] = sign_bit & ~req_unsigned;
        end
    end

    always_comb begin
        st_be = '0;
        for (int i = 0; i < BYTES; i++) begin
            st_be[i] = (i >= int'(req_off)) &&
                       (i < int'(req_off) + int'(n_bytes));
        end
    end

    always_comb begin
        fmt_err  = illegal | misaligned;
        fmt_data = req_store ? st_data : ld_data;
        fmt_be   = req_store ? st_be : '0;
        if (fmt_err) begin
            fmt_data = '0;
            fmt_be   = '0;
        end
    end

endmodule

// File: rtl/load_store_align.sv
// Load/store alignment stage with a 2-entry response buffer
// and a saturating error counter.
module load_store_align
    import load_store_align_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int BYTES  = DATA_W / 8,
    parameter int OFF_W  = $clog2(BYTES),
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [OFF_W-1:0]  req_off,
    input  logic [DATA_W-1:0] req_rdata,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [BYTES-1:0]  rsp_be,
    output logic              rsp_err,
    output logic [CNT_W-1:0]  err_count
);

    logic [DATA_W-1:0] f_data;
    logic [BYTES-1:0]  f_be;
    logic              f_err;
    rsp_t              fmt;

    rsp_t              ent0_q, ent0_d;
    rsp_t              ent1_q, ent1_d;
    logic [1:0]        count_q, count_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic              push;
    logic              pop;

    lsa_format #(
        .DATA_W (DATA_W),
        .BYTES  (BYTES),
        .OFF_W  (OFF_W)
    ) u_format (
        .req_store    (req_store),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_off      (req_off),
        .req_rdata    (req_rdata),
        .req_wdata    (req_wdata),
        .fmt_data     (f_data),
        .fmt_be       (f_be),
        .fmt_err      (f_err)
    );

    always_comb begin
        fmt                   = '0;
        fmt.data[DATA_W-1:0]  = f_data;
        fmt.be[BYTES-1:0]     = f_be;
        fmt.err               = f_err;
    end

    assign req_ready = (count_q != 2'd2);
    assign rsp_valid = (count_q != 2'd0);
    assign push      = req_valid & req_ready;
    assign pop       = rsp_valid & rsp_ready;

    // Entry 0 is always the head; entry 1 shifts down on a pop.
    always_comb begin
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        count_d = count_q;
        unique case (count_q)
            2'd0: begin
                if (push) begin
                    ent0_d  = fmt;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    ent0_d = fmt;
                end else if (push) begin
                    ent1_d  = fmt;
                    count_d = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    ent0_d  = ent1_q;
                    count_d = 2'd1;
                end
            end
        endcase
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (push && f_err && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q    <= '0;
            ent1_q    <= '0;
            count_q   <= 2'd0;
            err_cnt_q <= '0;
        end else begin
            ent0_q    <= ent0_d;
            ent1_q    <= ent1_d;
            count_q   <= count_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign rsp_data  = ent0_q.data[DATA_W-1:0];
    assign rsp_be    = ent0_q.be[BYTES-1:0];
    assign rsp_err   = ent0_q.err;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_load_store_align.sv
// Directed bench for load_store_align (DATA_W=32, CNT_W=2).
module tb_load_store_align;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [1:0]  req_off;
    logic [31:0] req_rdata;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_be;
    logic        rsp_err;
    logic [1:0]  err_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    load_store_align #(
        .DATA_W (32),
        .CNT_W  (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_store    (req_store),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_off      (req_off),
        .req_rdata    (req_rdata),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_be       (rsp_be),
        .rsp_err      (rsp_err),
        .err_count    (err_count)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic st, input logic [1:0] sz,
                           input logic uns, input logic [1:0] off,
                           input logic [31:0] rd, input logic [31:0] wd);
        req_valid    = 1'b1;
        req_store    = st;
        req_size     = sz;
        req_unsigned = uns;
        req_off      = off;
        req_rdata    = rd;
        req_wdata    = wd;
    endtask

    // One request with rsp_ready=1; checked half a cycle after acceptance.
    task automatic one(input string tag, input logic st, input logic [1:0] sz,
                       input logic uns, input logic [1:0] off,
                       input logic [31:0] rd, input logic [31:0] wd,
                       input logic [31:0] e_data, input logic [3:0] e_be,
                       input logic e_err);
        @(negedge clk);
        set_req(st, sz, uns, off, rd, wd);
        @(negedge clk);
        req_valid = 1'b0;
        check({tag, ".valid"}, 64'(rsp_valid), 64'd1);
        check({tag, ".data"}, 64'(rsp_data), 64'(e_data));
        check({tag, ".be"}, 64'(rsp_be), 64'(e_be));
        check({tag, ".err"}, 64'(rsp_err), 64'(e_err));
    endtask

    initial begin
        logic [31:0] exp_q [$];
        logic [31:0] e;

        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        set_req(1'b0, 2'd0, 1'b0, 2'd0, 32'h0, 32'h0);
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.valid", 64'(rsp_valid), 64'd0);
        check("rst.ready", 64'(req_ready), 64'd1);
        check("rst.data", 64'(rsp_data), 64'd0);
        check("rst.be", 64'(rsp_be), 64'd0);
        check("rst.err", 64'(rsp_err), 64'd0);
        check("rst.cnt", 64'(err_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        one("ldb_s", 0, 0, 0, 0, 32'h8765_43A1, 0, 32'hFFFF_FFA1, 4'h0, 0);
        one("ldb_u", 0, 0, 1, 0, 32'h8765_43A1, 0, 32'h0000_00A1, 4'h0, 0);
        one("ldh_s", 0, 1, 0, 2, 32'h8765_43A1, 0, 32'hFFFF_8765, 4'h0, 0);
        one("ldb3u", 0, 0, 1, 3, 32'h8765_43A1, 0, 32'h0000_0087, 4'h0, 0);
        one("ldh0s", 0, 1, 0, 0, 32'h8765_43A1, 0, 32'h0000_43A1, 4'h0, 0);
        one("ldw", 0, 2, 0, 0, 32'h8765_43A1, 0, 32'h8765_43A1, 4'h0, 0);
        one("sth2", 1, 1, 0, 2, 0, 32'h1234_BEEF, 32'hBEEF_BEEF, 4'hC, 0);
        one("stb1", 1, 0, 0, 1, 0, 32'h1234_BEEF, 32'hEFEF_EFEF, 4'h2, 0);
        one("stw", 1, 2, 0, 0, 0, 32'h1234_BEEF, 32'h1234_BEEF, 4'hF, 0);
        check("cnt0", 64'(err_count), 64'd0);
        one("mis_w1", 0, 2, 0, 1, 32'h8765_43A1, 0, 32'h0, 4'h0, 1);
        check("cnt1", 64'(err_count), 64'd1);
        one("ill_d", 1, 3, 0, 0, 0, 32'h1234_BEEF, 32'h0, 4'h0, 1);
        check("cnt2", 64'(err_count), 64'd2);
        @(negedge clk);
        check("drain.valid", 64'(rsp_valid), 64'd0);

        // Backpressure: two accepted, third blocked, head held stable.
        rsp_ready = 1'b0;
        set_req(0, 2, 0, 0, 32'h1111_1111, 0);
        @(negedge clk);
        set_req(0, 2, 0, 0, 32'h2222_2222, 0);
        @(negedge clk);
        set_req(0, 2, 0, 0, 32'h3333_3333, 0);
        check("bp.ready", 64'(req_ready), 64'd0);
        check("bp.head", 64'(rsp_data), 64'h1111_1111);
        @(negedge clk);
        check("bp.ready2", 64'(req_ready), 64'd0);
        check("bp.hold", 64'(rsp_data), 64'h1111_1111);
        check("bp.hvalid", 64'(rsp_valid), 64'd1);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp.second", 64'(rsp_data), 64'h2222_2222);
        check("bp.valid2", 64'(rsp_valid), 64'd1);
        check("bp.ready3", 64'(req_ready), 64'd1);
        @(negedge clk);
        check("bp.empty", 64'(rsp_valid), 64'd0);

        // Streaming: byte stores, each response trails its request by one cycle.
        for (int i = 0; i < 8; i++) begin
            logic [7:0] b;
            b = 8'(8'h30 + 8'(i * 13));
            set_req(1, 0, 0, 2'(i), 0, {24'h0, b});
            exp_q.push_back({b, b, b, b});
            @(negedge clk);
            e = exp_q.pop_front();
            check("st.valid", 64'(rsp_valid), 64'd1);
            check("st.ready", 64'(req_ready), 64'd1);
            check("st.data", 64'(rsp_data), 64'(e));
            check("st.be", 64'(rsp_be), 64'(4'b0001 << (i % 4)));
        end
        req_valid = 1'b0;
        @(negedge clk);
        check("st.empty", 64'(rsp_valid), 64'd0);

        // Reset with two entries buffered.
        rsp_ready = 1'b0;
        set_req(0, 2, 0, 0, 32'hAAAA_0001, 0);
        @(negedge clk);
        set_req(0, 2, 0, 0, 32'hAAAA_0002, 0);
        @(negedge clk);
        req_valid = 1'b0;
        check("rr.full", 64'(req_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rr.valid", 64'(rsp_valid), 64'd0);
        check("rr.ready", 64'(req_ready), 64'd1);
        check("rr.cnt", 64'(err_count), 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rr.stale", 64'(rsp_valid), 64'd0);
        check("rr.data", 64'(rsp_data), 64'd0);

        // Saturation of the 2-bit error counter.
        for (int i = 0; i < 5; i++) begin
            set_req(0, 1, 0, 2'd1, 32'h5, 0);
            @(negedge clk);
            check("sat.err", 64'(rsp_err), 64'd1);
            check("sat.cnt", 64'(err_count), 64'(i < 3 ? i + 1 : 3));
        end
        req_valid = 1'b0;
        @(negedge clk);
        check("sat.final", 64'(err_count), 64'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
